// File: rtl/ldpc_sched_pkg.sv
// Shared types and helpers for the LDPC mux-select scheduler.
// State encoding and the modular select step live here.
package ldpc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } state_t;

    localparam int SEL_MAX = 8;

    // Single conditional subtract; operands are already below m.
    function automatic logic [SEL_MAX-1:0] mod_add(
        input logic [SEL_MAX-1:0] a,
        input logic [SEL_MAX-1:0] b,
        input logic [SEL_MAX-1:0] m
    );
        logic [SEL_MAX:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m})
            s = s - {1'b0, m};
        return s[SEL_MAX-1:0];
    endfunction

endpackage

// File: rtl/ldpc_modstep.sv
// Combinational mod-MUXSIZE adder for the select walk.
// y = (a + b) mod MUXSIZE, given a, b < MUXSIZE.
module ldpc_modstep
    import ldpc_sched_pkg::*;
#(
    parameter int SELBITS = 2,
    parameter int MUXSIZE = 4
) (
    input  logic [SELBITS-1:0] a,
    input  logic [SELBITS-1:0] b,
    output logic [SELBITS-1:0] y
);

    assign y = SELBITS'(mod_add(SEL_MAX'(a), SEL_MAX'(b),
                                SEL_MAX'(MUXSIZE)));

endmodule

// File: rtl/ldpc_muxsel_sched.sv
// Select scheduler for an ldpc_muxreg bank: strided walk of mux
// inputs with flags aligned to the mux register latency.
module ldpc_muxsel_sched
    import ldpc_sched_pkg::*;
#(
    parameter int SELBITS = 2,
    parameter int MUXSIZE = 4,
    parameter int CNTBITS = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNTBITS-1:0] num_steps,
    input  logic [SELBITS-1:0] base_sel,
    input  logic [SELBITS-1:0] stride,
    input  logic               abort,
    output logic               busy,
    output logic [SELBITS-1:0] sel,
    output logic               sel_valid,
    output logic [CNTBITS-1:0] step_idx,
    output logic               dout_valid,
    output logic               done
);

    localparam logic [SELBITS:0] MUX_W = (SELBITS+1)'(MUXSIZE);

    state_t             state, state_d;
    logic [SELBITS-1:0] sel_d, stride_q, stride_d, sel_nxt;
    logic [CNTBITS-1:0] step_d, num_q, num_d;
    logic               sel_valid_d, dout_valid_d, busy_d, done_d;
    logic               last;

    ldpc_modstep #(
        .SELBITS(SELBITS),
        .MUXSIZE(MUXSIZE)
    ) u_step (
        .a(sel),
        .b(stride_q),
        .y(sel_nxt)
    );

    assign last = (step_idx == num_q - CNTBITS'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sel        <= '0;
            step_idx   <= '0;
            num_q      <= '0;
            stride_q   <= '0;
            sel_valid  <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            sel        <= sel_d;
            step_idx   <= step_d;
            num_q      <= num_d;
            stride_q   <= stride_d;
            sel_valid  <= sel_valid_d;
            dout_valid <= dout_valid_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    always_comb begin
        state_d      = state;
        sel_d        = sel;
        step_d       = step_idx;
        num_d        = num_q;
        stride_d     = stride_q;
        sel_valid_d  = 1'b0;
        dout_valid_d = sel_valid & ~abort;
        busy_d       = busy;
        done_d       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    num_d    = num_steps;
                    stride_d = stride;
                    busy_d   = 1'b1;
                    if (num_steps != '0) begin
                        state_d     = RUN;
                        sel_d       = base_sel;
                        step_d      = '0;
                        sel_valid_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (last) begin
                    state_d = DRAIN;
                    done_d  = 1'b1;
                end else begin
                    sel_d       = sel_nxt;
                    step_d      = step_idx + CNTBITS'(1);
                    sel_valid_d = 1'b1;
                end
            end
            DRAIN: begin
                // Zero-step runs reach here without a done; pulse it now.
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = !done && !abort;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always @(posedge clk) begin
        if (rst && state == IDLE && start && !abort) begin
            assert ({1'b0, base_sel} < MUX_W)
                else $error("base_sel %0d out of range", base_sel);
            assert ({1'b0, stride} < MUX_W)
                else $error("stride %0d out of range", stride);
        end
    end

endmodule

// File: tb/tb_ldpc_muxsel_sched.sv
// Directed bench for ldpc_muxsel_sched, MUXSIZE=4 and MUXSIZE=3.
// Cycle 0 is the cycle in which start is held high.
module tb_ldpc_muxsel_sched;

    logic       clk, rst, start, abort;
    logic [4:0] num_steps;
    logic [1:0] base_sel, stride;

    logic       b4, sv4, dv4, dn4;
    logic [1:0] s4;
    logic [4:0] si4;
    logic       b3, sv3, dv3, dn3;
    logic [1:0] s3;
    logic [4:0] si3;

    int passed = 0;
    int total  = 0;

    ldpc_muxsel_sched #(.SELBITS(2), .MUXSIZE(4), .CNTBITS(5)) dut4 (
        .clk(clk), .rst(rst), .start(start), .num_steps(num_steps),
        .base_sel(base_sel), .stride(stride), .abort(abort),
        .busy(b4), .sel(s4), .sel_valid(sv4), .step_idx(si4),
        .dout_valid(dv4), .done(dn4)
    );

    ldpc_muxsel_sched #(.SELBITS(2), .MUXSIZE(3), .CNTBITS(5)) dut3 (
        .clk(clk), .rst(rst), .start(start), .num_steps(num_steps),
        .base_sel(base_sel), .stride(stride), .abort(abort),
        .busy(b3), .sel(s3), .sel_valid(sv3), .step_idx(si3),
        .dout_valid(dv3), .done(dn3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic go(input logic [1:0] b, input logic [1:0] s,
                      input logic [4:0] n);
        base_sel  = b;
        stride    = s;
        num_steps = n;
        start     = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int e1[6] = '{1, 2, 3, 0, 1, 2};
        int e2[4] = '{2, 1, 0, 2};
        int cnt, bad, donec;
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        num_steps = '0; base_sel = '0; stride = '0;

        // reset state
        tick(); tick();
        chk("rst_busy", b4, 0);
        chk("rst_sel", s4, 0);
        chk("rst_sv", sv4, 0);
        chk("rst_step", si4, 0);
        chk("rst_dv", dv4, 0);
        chk("rst_done", dn4, 0);
        rst = 1'b1;
        tick();

        // base 1 stride 1, six steps, MUXSIZE 4
        go(2'd1, 2'd1, 5'd6);
        for (int c = 1; c <= 8; c++) begin
            if (c <= 6) begin
                chk($sformatf("t1_sel_c%0d", c), s4, e1[c-1]);
                chk($sformatf("t1_step_c%0d", c), si4, c - 1);
            end
            chk($sformatf("t1_sv_c%0d", c), sv4, 32'(c <= 6));
            chk($sformatf("t1_dv_c%0d", c), dv4, 32'(c >= 2 && c <= 7));
            chk($sformatf("t1_done_c%0d", c), dn4, 32'(c == 7));
            chk($sformatf("t1_busy_c%0d", c), b4, 32'(c <= 7));
            tick();
        end

        // MUXSIZE 3 wrap: base 2 stride 2
        go(2'd2, 2'd2, 5'd4);
        for (int c = 1; c <= 5; c++) begin
            if (c <= 4)
                chk($sformatf("t2_sel_c%0d", c), s3, e2[c-1]);
            chk($sformatf("t2_sv_c%0d", c), sv3, 32'(c <= 4));
            chk($sformatf("t2_no3_c%0d", c), 32'(s3 == 2'd3), 0);
            chk($sformatf("t2_done_c%0d", c), dn3, 32'(c == 5));
            tick();
        end
        tick();

        // zero steps
        go(2'd0, 2'd0, 5'd0);
        chk("t3_busy_c1", b4, 1);
        chk("t3_sv_c1", sv4, 0);
        chk("t3_done_c1", dn4, 0);
        tick();
        chk("t3_done_c2", dn4, 1);
        chk("t3_busy_c2", b4, 0);
        chk("t3_dv_c2", dv4, 0);
        chk("t3_sv_c2", sv4, 0);
        tick();
        chk("t3_done_c3", dn4, 0);
        tick();

        // abort on cycle 3, restart on cycle 5
        go(2'd0, 2'd1, 5'd6);
        tick(); tick();
        chk("t4_sv_c3", sv4, 1);
        chk("t4_sel_c3", s4, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_sv_c4", sv4, 0);
        chk("t4_dv_c4", dv4, 0);
        chk("t4_busy_c4", b4, 0);
        chk("t4_done_c4", dn4, 0);
        chk("t4_sel_hold", s4, 2);
        chk("t4_step_hold", si4, 2);
        tick();
        chk("t4_done_c5", dn4, 0);
        chk("t4_dv_c5", dv4, 0);
        go(2'd0, 2'd1, 5'd3);
        for (int c = 1; c <= 5; c++) begin
            if (c <= 3)
                chk($sformatf("t4r_sel_c%0d", c), s4, c - 1);
            chk($sformatf("t4r_sv_c%0d", c), sv4, 32'(c <= 3));
            chk($sformatf("t4r_done_c%0d", c), dn4, 32'(c == 4));
            chk($sformatf("t4r_busy_c%0d", c), b4, 32'(c <= 4));
            tick();
        end

        // start re-pulsed during RUN is ignored
        go(2'd1, 2'd1, 5'd3);
        for (int c = 1; c <= 5; c++) begin
            if (c <= 3)
                chk($sformatf("t5_sel_c%0d", c), s4, c);
            chk($sformatf("t5_sv_c%0d", c), sv4, 32'(c <= 3));
            chk($sformatf("t5_done_c%0d", c), dn4, 32'(c == 4));
            chk($sformatf("t5_busy_c%0d", c), b4, 32'(c <= 4));
            if (c == 2) begin
                base_sel  = 2'd0;
                stride    = 2'd2;
                num_steps = 5'd5;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        tick();

        // async reset mid-run
        go(2'd0, 2'd1, 5'd6);
        tick();
        #2 rst = 1'b0;
        #1;
        chk("t6_busy", b4, 0);
        chk("t6_sel", s4, 0);
        chk("t6_sv", sv4, 0);
        chk("t6_step", si4, 0);
        chk("t6_dv", dv4, 0);
        chk("t6_done", dn4, 0);
        chk("t6_busy3", b3, 0);
        tick();
        chk("t6_done_held", dn4, 0);
        rst = 1'b1;
        tick();
        go(2'd2, 2'd1, 5'd2);
        for (int c = 1; c <= 4; c++) begin
            if (c <= 2)
                chk($sformatf("t6r_sel_c%0d", c), s4, c + 1);
            chk($sformatf("t6r_sv_c%0d", c), sv4, 32'(c <= 2));
            chk($sformatf("t6r_done_c%0d", c), dn4, 32'(c == 3));
            tick();
        end

        // max num_steps with stride 0
        cnt = 0; bad = 0; donec = 0;
        go(2'd2, 2'd0, 5'd31);
        for (int c = 1; c <= 40; c++) begin
            if (sv4) begin
                cnt++;
                if (s4 != 2'd2) bad++;
            end
            if (dn4) begin
                donec = c;
                break;
            end
            tick();
        end
        chk("t7_count", cnt, 31);
        chk("t7_const_sel", bad, 0);
        chk("t7_done_cycle", donec, 32);
        tick();
        chk("t7_idle_busy", b4, 0);
        chk("t7_idle_done", dn4, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
